perf_event_counter: RTL and testbench
=====================================

// Module: perf_event_counter
// PURPOSE
//  Synthesizable, parametrised replacement for the bench-side stall/flush/cycle tallies.
//  Sits beside the pipelined CPU and counts cycles plus NUM_CH qualified events
//  (e.g. hazard stall, branch flush, retire). Stops itself after a programmable
//  cycle limit and exposes the counts through a registered read port.
// PARAMETERS
//  NUM_CH    4   number of event channels (1..15)
//  CNT_W     32  width of every counter
//  LIMIT     30  counted cycles before DONE; 0 = never stop
//  SATURATE  0   1 = counters saturate at all-ones; 0 = counters wrap to 0
// PORTS
//  clk_i       in   1                 clock
//  rst_n_i     in   1                 synchronous active-low reset
//  start_i     in   1                 level enable; counting only while high
//  freeze_i    in   1                 hold all counters (pause without losing state)
//  clear_i     in   1                 synchronous clear of counters/state to IDLE
//  event_i     in   NUM_CH            per-channel event strobe
//  inhibit_i   in   NUM_CH            per-channel qualifier; event ignored when high
//  rd_sel_i    in   4                 0 = cycle counter, k = channel k-1
//  rd_data_o   out  CNT_W             selected counter, registered
//  done_o      out  1                 high in DONE state
//  ovf_o       out  NUM_CH+1          sticky overflow flags {ch[NUM_CH-1:0], cycle}
// BEHAVIOUR
//  - Reset (rst_n_i=0 at posedge clk_i): state IDLE, all counters 0, rd_data_o=0,
//    done_o=0, ovf_o=0. Reset overrides every other input.
//  - FSM: IDLE --start_i=1--> RUN; RUN --LIMIT-th counted cycle--> DONE;
//    any state --clear_i=1--> IDLE. DONE holds until clear_i or reset.
//  - "Counted cycle" = state RUN && start_i && !freeze_i. Counting also happens in the
//    IDLE->RUN transition cycle (start_i high in IDLE counts as cycle 1).
//  - On a counted cycle: cycle counter +1; channel k +1 iff event_i[k] && !inhibit_i[k].
//  - IDLE, DONE, freeze_i, or start_i low: all counters hold.
//  - DONE entered on the edge where the cycle counter becomes LIMIT; done_o high from
//    the following cycle (registered). Events of that LIMIT-th cycle are counted.
//  - LIMIT=0: DONE never entered; done_o stays 0.
//  - clear_i beats start_i/event_i in the same cycle: counters, ovf_o -> 0, state IDLE.
//  - Overflow at all-ones +1: SATURATE=1 holds all-ones; SATURATE=0 wraps to 0.
//  - rd_data_o <= value of counter rd_sel_i at the sampling edge (pre-increment);
//    1-cycle latency; rd_sel_i > NUM_CH returns 0. Read port active in every state.
//  - Widths: counter increments are CNT_W-bit unsigned; no carry beyond CNT_W.
// CONFIGURATION
//  PERF_OVF_FLAG_EN defined: ovf_o bit set (sticky) on the edge a counter overflows
//    (wraps or would exceed all-ones); cleared only by clear_i or reset.
//  PERF_OVF_FLAG_EN undefined: no overflow logic; ovf_o tied to 0. Counting unchanged.
// TESTING
//  1. reset low 2 cycles, then high; sample rd_sel_i=0..NUM_CH -> all rd_data_o=0, done_o=0.
//  2. LIMIT=30, start_i=1, event_i[0]=1 every cycle -> cycle=30, ch0=30, done_o=1; further
//     cycles leave both at 30.
//  3. event_i[1]=inhibit_i[1]=1 for 5 cycles, event_i[1]=1 alone for 3 -> ch1=3.
//  4. freeze_i=1 for 4 of 10 cycles -> cycle=6; clear_i with event_i[0]=1 same cycle -> all 0,
//     state IDLE.
//  5. CNT_W=4, SATURATE=0, 17 counted cycles -> cycle=1, ovf_o[0]=1 (macro on) / 0 (off);
//     SATURATE=1 -> cycle=15.
//  6. rd_sel_i=NUM_CH+1 -> rd_data_o=0 next cycle; reset asserted mid-RUN -> IDLE, counters 0.

Source files
------------

// File: rtl/perf_event_counter.sv
// ---------------------------------------------------------------------------
// perf_event_counter
//
// Counts clock cycles plus NUM_CH qualified event channels beside a pipelined
// CPU. It stops by itself after LIMIT counted cycles (LIMIT = 0 never stops)
// and exposes any counter through a registered read port.
//
// Parameters
//   NUM_CH    number of event channels (1..15)
//   CNT_W     width of every counter
//   LIMIT     counted cycles before DONE; 0 = never stop
//   SATURATE  1 = counters stick at all-ones; 0 = counters wrap to 0
//
// Ports
//   clk_i      clock
//   rst_n_i    synchronous active-low reset
//   start_i    level enable; counting only while high
//   freeze_i   hold all counters without losing state
//   clear_i    synchronous clear of counters/flags, state back to IDLE
//   event_i    per-channel event strobe
//   inhibit_i  per-channel qualifier; event ignored when high
//   rd_sel_i   0 = cycle counter, k = channel k-1, > NUM_CH reads 0
//   rd_data_o  selected counter, registered (value before the sampling edge)
//   done_o     high while in DONE
//   ovf_o      sticky overflow flags {ch[NUM_CH-1:0], cycle}
//
// Configuration macro
//   PERF_OVF_FLAG_EN  when defined, ovf_o bits are set on the edge a counter
//                     overflows; when undefined, ovf_o is tied to 0.
// ---------------------------------------------------------------------------
module perf_event_counter #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 32,
  parameter int LIMIT    = 30,
  parameter int SATURATE = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              freeze_i,
  input  logic              clear_i,
  input  logic [NUM_CH-1:0] event_i,
  input  logic [NUM_CH-1:0] inhibit_i,
  input  logic [3:0]        rd_sel_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic              done_o,
  output logic [NUM_CH:0]   ovf_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0]    CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]    CNT_ZERO  = {CNT_W{1'b0}};
  // LIMIT widened so a LIMIT that does not fit in CNT_W can never match.
  localparam logic [CNT_W+31:0]   LIMIT_EXT = (CNT_W+32)'(LIMIT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  ch_q [NUM_CH];
  logic [CNT_W-1:0]  ch_d [NUM_CH];
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;
  logic              done_q, done_d;
  logic              count_s;

  // Next counter value: all-ones either sticks or wraps depending on SATURATE.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] val);
    if (val == CNT_MAX) begin
      cnt_next = (SATURATE != 0) ? CNT_MAX : CNT_ZERO;
    end else begin
      cnt_next = val + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // An increment of an all-ones counter is an overflow in both modes.
  function automatic logic cnt_ovf(input logic [CNT_W-1:0] val);
    cnt_ovf = (val == CNT_MAX);
  endfunction

`ifdef PERF_OVF_FLAG_EN
  logic [NUM_CH:0] ovf_q, ovf_d;
`endif

  // IDLE with start_i high already counts, so the qualifier covers IDLE and RUN.
  assign count_s = start_i && !freeze_i && (state_q != ST_DONE);

  // Next-state, counter update and read-mux logic.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    ch_d      = ch_q;
    rd_data_d = CNT_ZERO;
`ifdef PERF_OVF_FLAG_EN
    ovf_d     = ovf_q;
`endif

    // Read port samples pre-update values and ignores clear_i.
    if (rd_sel_i == 4'd0) begin
      rd_data_d = cyc_q;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (rd_sel_i == 4'(k + 1)) begin
          rd_data_d = ch_q[k];
        end else begin
          rd_data_d = rd_data_d;
        end
      end
    end

    if (clear_i) begin
      state_d = ST_IDLE;
      cyc_d   = CNT_ZERO;
      for (int k = 0; k < NUM_CH; k++) begin
        ch_d[k] = CNT_ZERO;
      end
`ifdef PERF_OVF_FLAG_EN
      ovf_d   = {(NUM_CH+1){1'b0}};
`endif
    end else begin
      case (state_q)
        ST_IDLE: state_d = start_i ? ST_RUN : ST_IDLE;
        ST_RUN:  state_d = ST_RUN;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase

      if (count_s) begin
        cyc_d = cnt_next(cyc_q);
`ifdef PERF_OVF_FLAG_EN
        ovf_d[0] = ovf_q[0] | cnt_ovf(cyc_q);
`endif
        for (int k = 0; k < NUM_CH; k++) begin
          if (event_i[k] && !inhibit_i[k]) begin
            ch_d[k] = cnt_next(ch_q[k]);
`ifdef PERF_OVF_FLAG_EN
            ovf_d[k+1] = ovf_q[k+1] | cnt_ovf(ch_q[k]);
`endif
          end else begin
            ch_d[k] = ch_q[k];
          end
        end
        // DONE on the edge where the cycle counter reaches LIMIT.
        if ((LIMIT != 0) && ({32'd0, cyc_d} == LIMIT_EXT)) begin
          state_d = ST_DONE;
        end else begin
          state_d = state_d;
        end
      end else begin
        cyc_d = cyc_q;
      end
    end

    done_d = (state_d == ST_DONE);
  end

  // State, counters and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cyc_q     <= CNT_ZERO;
      for (int k = 0; k < NUM_CH; k++) begin
        ch_q[k] <= CNT_ZERO;
      end
      rd_data_q <= CNT_ZERO;
      done_q    <= 1'b0;
`ifdef PERF_OVF_FLAG_EN
      ovf_q     <= {(NUM_CH+1){1'b0}};
`endif
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      ch_q      <= ch_d;
      rd_data_q <= rd_data_d;
      done_q    <= done_d;
`ifdef PERF_OVF_FLAG_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign rd_data_o = rd_data_q;
  assign done_o    = done_q;
`ifdef PERF_OVF_FLAG_EN
  assign ovf_o     = ovf_q;
`else
  assign ovf_o     = {(NUM_CH+1){1'b0}};
`endif

endmodule

// File: tb/tb_perf_event_counter.sv
// Bench for perf_event_counter: three instances share stimulus
//   0: NUM_CH=4, CNT_W=32, LIMIT=30, wrap
//   1: NUM_CH=4, CNT_W=4,  LIMIT=0,  wrap
//   2: NUM_CH=4, CNT_W=4,  LIMIT=0,  saturate
// Reference model keeps unbounded event totals and derives counter values.
module tb_perf_event_counter;

  logic        clk = 1'b0;
  logic        rst_n, start, freeze, clear;
  logic [3:0]  ev, inh, sel;
  logic [31:0] rd_m;
  logic [3:0]  rd_w, rd_s;
  logic        done_m, done_w, done_s;
  logic [4:0]  ovf_m, ovf_w, ovf_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  perf_event_counter #(.NUM_CH(4), .CNT_W(32), .LIMIT(30), .SATURATE(0)) u_dut_m (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .freeze_i(freeze), .clear_i(clear),
    .event_i(ev), .inhibit_i(inh), .rd_sel_i(sel),
    .rd_data_o(rd_m), .done_o(done_m), .ovf_o(ovf_m));

  perf_event_counter #(.NUM_CH(4), .CNT_W(4), .LIMIT(0), .SATURATE(0)) u_dut_w (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .freeze_i(freeze), .clear_i(clear),
    .event_i(ev), .inhibit_i(inh), .rd_sel_i(sel),
    .rd_data_o(rd_w), .done_o(done_w), .ovf_o(ovf_w));

  perf_event_counter #(.NUM_CH(4), .CNT_W(4), .LIMIT(0), .SATURATE(1)) u_dut_s (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .freeze_i(freeze), .clear_i(clear),
    .event_i(ev), .inhibit_i(inh), .rd_sel_i(sel),
    .rd_data_o(rd_s), .done_o(done_s), .ovf_o(ovf_s));

  // ---------------- reference model ----------------
  int     lim [3] = '{30, 0, 0};
  int     wid [3] = '{32, 4, 4};
  int     sat [3] = '{0, 1 - 1, 1};
  int     mode [3];            // 0 idle, 1 run, 2 done
  longint tot_cyc [3];
  longint tot_ch [3][4];

  function automatic longint max_of(int i);
    return (longint'(1) << wid[i]) - 1;
  endfunction

  function automatic longint shown(int i, longint t);
    if (sat[i] != 0) return (t > max_of(i)) ? max_of(i) : t;
    else             return t & max_of(i);
  endfunction

  function automatic longint exp_rd(int i);
    if (sel == 4'd0) return shown(i, tot_cyc[i]);
    if (sel <= 4'd4) return shown(i, tot_ch[i][sel - 4'd1]);
    return 0;
  endfunction

  function automatic longint exp_ovf(int i);
    longint r = 0;
`ifdef PERF_OVF_FLAG_EN
    if (tot_cyc[i] > max_of(i)) r = r | 1;
    for (int k = 0; k < 4; k++)
      if (tot_ch[i][k] > max_of(i)) r = r | (longint'(1) << (k + 1));
`endif
    return r;
  endfunction

  function automatic longint got_rd(int i);
    case (i)
      0: return longint'(rd_m);
      1: return longint'(rd_w);
      default: return longint'(rd_s);
    endcase
  endfunction

  function automatic longint got_done(int i);
    case (i)
      0: return longint'(done_m);
      1: return longint'(done_w);
      default: return longint'(done_s);
    endcase
  endfunction

  function automatic longint got_ovf(int i);
    case (i)
      0: return longint'(ovf_m);
      1: return longint'(ovf_w);
      default: return longint'(ovf_s);
    endcase
  endfunction

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (!rst_n || clear) begin
        mode[i] = 0;
        tot_cyc[i] = 0;
        for (int k = 0; k < 4; k++) tot_ch[i][k] = 0;
      end else begin
        bit counted;
        counted = start && !freeze && (mode[i] != 2);
        if (mode[i] == 0 && start) mode[i] = 1;
        if (counted) begin
          tot_cyc[i]++;
          for (int k = 0; k < 4; k++)
            if (ev[k] && !inh[k]) tot_ch[i][k]++;
          if (lim[i] != 0 && tot_cyc[i] == longint'(lim[i])) mode[i] = 2;
        end
      end
    end
  endtask

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: capture expected read data, advance DUT and model, compare.
  task automatic tick();
    longint pre [3];
    for (int i = 0; i < 3; i++) pre[i] = rst_n ? exp_rd(i) : 0;
    @(posedge clk);
    #1;
    model_step();
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("rd%0d", i),   got_rd(i),   pre[i]);
      check_val($sformatf("done%0d", i), got_done(i), (mode[i] == 2) ? 1 : 0);
      check_val($sformatf("ovf%0d", i),  got_ovf(i),  exp_ovf(i));
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; freeze = 1'b0; clear = 1'b0; ev = 4'd0; inh = 4'd0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      mode[i] = 0; tot_cyc[i] = 0;
      for (int k = 0; k < 4; k++) tot_ch[i][k] = 0;
    end
    rst_n = 1'b0; sel = 4'd0;
    idle_inputs();

    // Reset, then every counter reads 0.
    tick(); tick();
    rst_n = 1'b1;
    for (int s = 0; s <= 4; s++) begin
      sel = 4'(s);
      tick();
      check_val("rst_rd", longint'(rd_m), 0);
      check_val("rst_done", longint'(done_m), 0);
    end

    // Run to LIMIT with ch0 firing every cycle, then a few extra cycles.
    start = 1'b1; ev = 4'b0001;
    for (int c = 0; c < 35; c++) begin
      sel = 4'($urandom_range(0, 5));
      tick();
    end
    idle_inputs();
    sel = 4'd0; tick(); check_val("lim_cyc", longint'(rd_m), 30);
    sel = 4'd1; tick(); check_val("lim_ch0", longint'(rd_m), 30);
    check_val("lim_done", longint'(done_m), 1);

    // Inhibit qualifies channel 1.
    clear = 1'b1; tick(); clear = 1'b0;
    start = 1'b1; ev = 4'b0010; inh = 4'b0010;
    for (int c = 0; c < 5; c++) tick();
    inh = 4'b0000;
    for (int c = 0; c < 3; c++) tick();
    idle_inputs();
    sel = 4'd2; tick(); check_val("inh_ch1", longint'(rd_m), 3);

    // Freeze 4 of 10 cycles, then clear beats start/event.
    clear = 1'b1; tick(); clear = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      freeze = (c >= 3 && c < 7);
      tick();
    end
    idle_inputs();
    sel = 4'd0; tick(); check_val("frz_cyc", longint'(rd_m), 6);
    clear = 1'b1; start = 1'b1; ev = 4'b0001; tick();
    idle_inputs();
    sel = 4'd0; tick(); check_val("clr_cyc", longint'(rd_m), 0);
    sel = 4'd1; tick(); check_val("clr_ch0", longint'(rd_m), 0);
    check_val("clr_done", longint'(done_m), 0);

    // 17 counted cycles on the 4-bit counters.
    clear = 1'b1; tick(); clear = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 17; c++) tick();
    idle_inputs();
    sel = 4'd0; tick();
    check_val("wrap_cyc", longint'(rd_w), 1);
    check_val("sat_cyc", longint'(rd_s), 15);
`ifdef PERF_OVF_FLAG_EN
    check_val("wrap_ovf0", longint'(ovf_w[0]), 1);
`else
    check_val("wrap_ovf0", longint'(ovf_w[0]), 0);
`endif

    // Out-of-range select, then reset in the middle of a run.
    sel = 4'd5; tick(); tick(); check_val("sel_oor", longint'(rd_w), 0);
    sel = 4'd15; tick(); tick(); check_val("sel_15", longint'(rd_m), 0);
    clear = 1'b1; tick(); clear = 1'b0;
    start = 1'b1; ev = 4'b1111;
    for (int c = 0; c < 5; c++) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    idle_inputs();
    sel = 4'd0; tick(); check_val("rst_run_cyc", longint'(rd_m), 0);
    sel = 4'd4; tick(); check_val("rst_run_ch3", longint'(rd_m), 0);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      rst_n  = ($urandom_range(0, 299) != 0);
      clear  = ($urandom_range(0, 59) == 0);
      start  = ($urandom_range(0, 7) != 0);
      freeze = ($urandom_range(0, 4) == 0);
      ev     = 4'($urandom);
      inh    = 4'($urandom) & 4'($urandom);
      sel    = 4'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
